project_mux_ctrl: RTL and testbench

// Parametrised successor of the caravel multi-project harness: a Wishbone slave that selects one of
// NUM_PROJ user projects onto the IO pads, and keeps one OEB register per project.

---
 rtl/project_mux_pkg.sv | 18 +
 rtl/mux_switch_seq.sv | 81 ++++++++
 rtl/project_mux_ctrl.sv | 136 +++++++++++++
 tb/tb_project_mux_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/project_mux_pkg.sv
// Shared types and register map for the multi-project pad multiplexer.
package project_mux_pkg;

  typedef enum logic [1:0] {
    ST_LIVE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_RST   = 2'd2
  } state_t;

  localparam logic [7:0] OFF_SELECT   = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_OEB_BASE = 8'h40;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_BAD_SEL  = 1;
  localparam int unsigned STAT_SOFT_RST = 2;

endpackage

// File: rtl/mux_switch_seq.sv
// Switch sequencer: LIVE -> GUARD -> RST -> LIVE with a shared down-counter.
module mux_switch_seq
  import project_mux_pkg::*;
#(
  parameter int unsigned GUARD_CYC = 16,
  parameter int unsigned RST_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       soft_rst,
  input  logic [7:0] target,
  output state_t     state,
  output logic [7:0] sel,
  output logic       busy
);

  localparam int unsigned MAX_CYC = (GUARD_CYC > RST_CYC) ? GUARD_CYC : RST_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC);
  localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [7:0]       sel_nxt;

  // State, counter and selected-project registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      count <= RST_LD;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      sel   <= sel_nxt;
    end
  end

  // Next-state logic; the counter counts down to 1 and reloads on each phase entry
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    sel_nxt   = sel;
    case (state)
      ST_LIVE: begin
        if (req) begin
          state_nxt = ST_GUARD;
          count_nxt = GUARD_LD;
          sel_nxt   = target;
        end else if (soft_rst) begin
          state_nxt = ST_RST;
          count_nxt = RST_LD;
        end
      end
      ST_GUARD: begin
        if (count == CNT_ONE) begin
          state_nxt = ST_RST;
          count_nxt = RST_LD;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
      ST_RST: begin
        if (count == CNT_ONE) begin
          state_nxt = ST_LIVE;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RST;
        count_nxt = RST_LD;
      end
    endcase
  end

  assign busy = (state != ST_LIVE);

endmodule

// File: rtl/project_mux_ctrl.sv
// Wishbone-controlled multiplexer of NUM_PROJ user projects onto the IO pads.
module project_mux_ctrl
  import project_mux_pkg::*;
#(
  parameter int unsigned NUM_PROJ  = 8,
  parameter int unsigned IO_PADS   = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned GUARD_CYC = 16,
  parameter int unsigned RST_CYC   = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_adr_i,
  input  logic [31:0]                  wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [IO_PADS-1:0]           io_in,
  output logic [IO_PADS-1:0]           io_out,
  output logic [IO_PADS-1:0]           io_oeb,
  output logic [NUM_PROJ*IO_PADS-1:0]  proj_io_in_o,
  input  logic [NUM_PROJ*IO_PADS-1:0]  proj_io_out_i,
  output logic [NUM_PROJ-1:0]          proj_rst_o
);

  logic [IO_PADS-1:0] oeb [NUM_PROJ];
  logic               bad_sel;
  logic [31:0]        rdata;
  state_t             state;
  logic [7:0]         cur_sel;
  logic               busy;

  logic       valid, access, wr_word;
  logic [7:0] off;
  logic [7:0] sel_val;
  logic       sel_wr, stat_wr, sel_bad, req, soft_rst;

  assign off     = wbs_adr_i[7:0];
  assign valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access  = valid & ~wbs_ack_o;
  assign wr_word = access & wbs_we_i & (wbs_sel_i == 4'hF);
  assign sel_val = wbs_dat_i[7:0];
  assign sel_wr  = access & wbs_we_i & wbs_sel_i[0] & (off == OFF_SELECT);
  assign stat_wr = access & wbs_we_i & wbs_sel_i[0] & (off == OFF_STATUS);
  assign sel_bad = sel_wr & (busy | (sel_val >= 8'(NUM_PROJ)));
  assign req      = sel_wr & ~sel_bad & (sel_val != cur_sel);
  assign soft_rst = stat_wr & wbs_dat_i[STAT_SOFT_RST];

  mux_switch_seq #(
    .GUARD_CYC (GUARD_CYC),
    .RST_CYC   (RST_CYC)
  ) u_seq (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .req      (req),
    .soft_rst (soft_rst),
    .target   (sel_val),
    .state    (state),
    .sel      (cur_sel),
    .busy     (busy)
  );

  // Sticky bad-select flag, cleared by writing 1 to its STATUS bit
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      bad_sel <= 1'b0;
    end else if (sel_bad) begin
      bad_sel <= 1'b1;
    end else if (stat_wr && wbs_dat_i[STAT_BAD_SEL]) begin
      bad_sel <= 1'b0;
    end
  end

  // Per-project OEB register file; full-word writes only
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int unsigned p = 0; p < NUM_PROJ; p++) oeb[p] <= '1;
    end else if (wr_word) begin
      for (int unsigned p = 0; p < NUM_PROJ; p++) begin
        if (off == OFF_OEB_BASE + 8'(8 * p))
          oeb[p][31:0] <= wbs_dat_i;
        if (off == OFF_OEB_BASE + 8'(8 * p + 4))
          oeb[p][IO_PADS-1:32] <= wbs_dat_i[IO_PADS-33:0];
      end
    end
  end

  // Read-data decode; unmapped offsets return 0
  always_comb begin
    rdata = '0;
    if (off == OFF_SELECT) rdata = {24'h0, cur_sel};
    if (off == OFF_STATUS) begin
      rdata[STAT_BUSY]    = busy;
      rdata[STAT_BAD_SEL] = bad_sel;
    end
    for (int unsigned p = 0; p < NUM_PROJ; p++) begin
      if (off == OFF_OEB_BASE + 8'(8 * p))     rdata = oeb[p][31:0];
      if (off == OFF_OEB_BASE + 8'(8 * p + 4)) rdata = 32'(oeb[p][IO_PADS-1:32]);
    end
  end

  // Single-cycle registered ack; read data is only non-zero alongside ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : '0;
    end
  end

  // Pad/project routing: only the selected project is connected, and never during GUARD
  always_comb begin
    io_out       = '0;
    io_oeb       = '1;
    proj_io_in_o = '0;
    proj_rst_o   = '1;
    for (int unsigned p = 0; p < NUM_PROJ; p++) begin
      if (8'(p) == cur_sel) begin
        if (state != ST_GUARD) begin
          io_oeb                             = oeb[p];
          proj_io_in_o[p*IO_PADS +: IO_PADS] = io_in;
        end
        if (state == ST_LIVE) begin
          io_out        = proj_io_out_i[p*IO_PADS +: IO_PADS];
          proj_rst_o[p] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Self-checking bench for project_mux_ctrl: register vector table plus switch-sequence scenarios.
module tb_project_mux_ctrl;

  localparam int NP  = 8;
  localparam int IOP = 38;
  localparam int PH_LIVE  = 0;
  localparam int PH_GUARD = 1;
  localparam int PH_RST   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat;
  logic              ack;
  logic [31:0]       dato;
  logic [IOP-1:0]    io_in, io_out, io_oeb;
  logic [NP*IOP-1:0] proj_in, proj_out;
  logic [NP-1:0]     proj_rst;

  logic [IOP-1:0] pval [NP];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  project_mux_ctrl #(
    .NUM_PROJ  (NP),
    .IO_PADS   (IOP),
    .BASE_ADDR (32'h3000_0000),
    .GUARD_CYC (16),
    .RST_CYC   (8)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (dato),
    .io_in         (io_in),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .proj_io_in_o  (proj_in),
    .proj_io_out_i (proj_out),
    .proj_rst_o    (proj_rst)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One bus transaction, bounded to 4 cycles waiting for ack
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic got, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        rd  = dato;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input string nm, input logic [31:0] a, input logic [31:0] d);
    logic g; logic [31:0] r;
    bus(1'b1, a, 4'hF, d, g, r);
    chk({nm, "_ack"}, 64'(g), 64'd1);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    logic g; logic [31:0] r;
    bus(1'b0, a, 4'hF, 32'h0, g, r);
    chk({nm, "_ack"}, 64'(g), 64'd1);
    chk(nm, 64'(r), 64'(e));
  endtask

  // Expected pad/project routing for a given phase and selected project
  task automatic check_pads(input string nm, input int ph, input int s, input logic [IOP-1:0] eoeb);
    logic [IOP-1:0]    e_out, e_oeb;
    logic [NP*IOP-1:0] e_in;
    logic [NP-1:0]     e_rst;
    e_out = '0; e_oeb = '1; e_in = '0; e_rst = '1;
    if (ph != PH_GUARD) begin
      e_oeb = eoeb;
      e_in[s*IOP +: IOP] = io_in;
    end
    if (ph == PH_LIVE) begin
      e_out    = pval[s];
      e_rst[s] = 1'b0;
    end
    checks++;
    if (io_out !== e_out || io_oeb !== e_oeb || proj_in !== e_in || proj_rst !== e_rst) begin
      errors++;
      $display("FAIL %s: io_out=%h exp %h io_oeb=%h exp %h rst=%h exp %h proj_in=%h exp %h",
               nm, io_out, e_out, io_oeb, e_oeb, proj_rst, e_rst, proj_in, e_in);
    end
  endtask

  initial begin
    logic        g;
    logic [31:0] r;
    int          ph;

    vecs[0]  = '{"oeb0_lo_wr",  1'b1, 32'h3000_0040, 4'hF, 32'hFFFF_00FF, 1'b1, 32'h0};
    vecs[1]  = '{"oeb0_hi_wr",  1'b1, 32'h3000_0044, 4'hF, 32'h0000_003F, 1'b1, 32'h0};
    vecs[2]  = '{"oeb0_lo_rd",  1'b0, 32'h3000_0040, 4'hF, 32'h0,         1'b1, 32'hFFFF_00FF};
    vecs[3]  = '{"oeb0_hi_rd",  1'b0, 32'h3000_0044, 4'hF, 32'h0,         1'b1, 32'h0000_003F};
    vecs[4]  = '{"select_rd",   1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[5]  = '{"status_rd",   1'b0, 32'h3000_0004, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{"oeb1_part",   1'b1, 32'h3000_0048, 4'h3, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{"oeb1_lo_rd",  1'b0, 32'h3000_0048, 4'hF, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[8]  = '{"oeb1_hi_rst", 1'b0, 32'h3000_004C, 4'hF, 32'h0,         1'b1, 32'h0000_003F};
    vecs[9]  = '{"unmapped_rd", 1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{"above_win",   1'b0, 32'h3000_0100, 4'hF, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{"below_win",   1'b0, 32'h2FFF_FFFC, 4'hF, 32'h0,         1'b0, 32'h0};
    vecs[12] = '{"oeb1_hi_wr",  1'b1, 32'h3000_004C, 4'hF, 32'hFFFF_FFC0, 1'b1, 32'h0};
    vecs[13] = '{"oeb1_hi_rd",  1'b0, 32'h3000_004C, 4'hF, 32'h0,         1'b1, 32'h0};

    pval[0] = 38'h00_0000_AB00;
    for (int p = 1; p < NP; p++) pval[p] = 38'h15_5555_5500 | IOP'(p);
    for (int p = 0; p < NP; p++) proj_out[p*IOP +: IOP] = pval[p];

    io_in = 38'h2A_1234_5678;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
    rst_n = 1'b0;

    // Reset state and release: 8 cycles in RST on project 0
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_dat", 64'(dato), 64'd0);
    check_pads("reset_pads", PH_RST, 0, '1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i == 7) check_pads("rst_last", PH_RST, 0, '1);
      if (i == 8) check_pads("rst_live", PH_LIVE, 0, '1);
    end

    // Register map vector table
    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, g, r);
      chk({vecs[i].nm, "_ack"}, 64'(g), 64'(vecs[i].exp_ack));
      if (!vecs[i].we && vecs[i].exp_ack) chk(vecs[i].nm, 64'(r), 64'(vecs[i].exp_rd));
    end
    @(posedge clk); #1;
    chk("dat_idle", 64'(dato), 64'd0);

    // Project 0 live with programmed OEB
    check_pads("p0_live", PH_LIVE, 0, 38'h3F_FFFF_00FF);

    // Switch to project 3: 16 GUARD, 8 RST, then LIVE
    wr("sel3", 32'h3000_0000, 32'd3);
    check_pads("sw3_s0", PH_GUARD, 3, '1);
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      ph = (i < 16) ? PH_GUARD : ((i < 24) ? PH_RST : PH_LIVE);
      check_pads($sformatf("sw3_s%0d", i), ph, 3, '1);
    end

    // Out-of-range select
    wr("sel9", 32'h3000_0000, 32'd9);
    rd_chk("stat_bad", 32'h3000_0004, 32'h2);
    rd_chk("sel_kept3", 32'h3000_0000, 32'd3);
    wr("clr_bad", 32'h3000_0004, 32'h2);
    rd_chk("stat_clr", 32'h3000_0004, 32'h0);

    // Select while busy is rejected
    wr("sel5", 32'h3000_0000, 32'd5);
    wr("sel6_busy", 32'h3000_0000, 32'd6);
    rd_chk("stat_busy_bad", 32'h3000_0004, 32'h3);
    rd_chk("sel_is5", 32'h3000_0000, 32'd5);
    repeat (30) @(posedge clk);
    #1;
    check_pads("p5_live", PH_LIVE, 5, '1);
    rd_chk("stat_live_bad", 32'h3000_0004, 32'h2);

    // OEB write to the live project takes effect right away
    wr("oeb5_lo", 32'h3000_0068, 32'h0000_FFFF);
    check_pads("p5_oeb", PH_LIVE, 5, 38'h3F_0000_FFFF);

    // Soft reset re-runs only the RST phase
    wr("clr_bad2", 32'h3000_0004, 32'h2);
    rd_chk("stat_clr2", 32'h3000_0004, 32'h0);
    wr("soft_rst", 32'h3000_0004, 32'h4);
    check_pads("soft_s0", PH_RST, 5, 38'h3F_0000_FFFF);
    repeat (7) @(posedge clk);
    #1;
    check_pads("soft_s7", PH_RST, 5, 38'h3F_0000_FFFF);
    @(posedge clk); #1;
    check_pads("soft_live", PH_LIVE, 5, 38'h3F_0000_FFFF);
    rd_chk("stat_soft_rd0", 32'h3000_0004, 32'h0);

    // Asynchronous reset in the middle of GUARD
    wr("sel2", 32'h3000_0000, 32'd2);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_pads("abort_pads", PH_RST, 0, '1);
    chk("abort_ack", 64'(ack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("abort_sel", 32'h3000_0000, 32'd0);
    rd_chk("abort_oeb0", 32'h3000_0040, 32'hFFFF_FFFF);
    check_pads("abort_rst", PH_RST, 0, '1);
    rd_chk("abort_busy", 32'h3000_0004, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
